axil_ctrl_initiator: RTL and testbench
======================================

AXIL_CTRL_INITIATOR -- requirements
Module: axil_ctrl_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: number of cycles to wait for B/R after the address is accepted before aborting; legal range 2..65535.
REQ-002 The clock is a single clock, and reset is asynchronous and active-high.
REQ-003 aclk  in  1  sole clock; all logic rising-edge.
REQ-004 areset  in  1  asynchronous active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  command handshake.
REQ-006 req_wr  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  AXI_ADDR_BITS  target register address.
REQ-008 req_wdata/req_wstrb  in  AXIL_DATA_BITS / AXIL_DATA_BITS/8  write payload.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  completion handshake.
REQ-010 rsp_rdata  out  AXIL_DATA_BITS  read data (0 for writes).
REQ-011 rsp_resp  out  2  AXI BRESP/RRESP, or 2'b10 on timeout.
REQ-012 rsp_timeout  out  1  completion was a timeout abort.
REQ-013 busy  out  1  high whenever the state is not IDLE or a drain is pending.
REQ-014 m_axi_ctrl_{awaddr,awprot,awvalid,awready,wdata,wstrb,wvalid,wready,bresp,bvalid,bready,araddr,arprot,arvalid,arready,rdata,rresp,rvalid,rready}  master side of AXI4L, widths per lynxTypes.

Function
REQ-015 The FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-016 req_ready SHALL be 1 only in IDLE with no drain pending; command is captured into registers on req_valid&&req_ready.
REQ-017 On capture, the next state SHALL be WR_REQ if req_wr=1 and RD_REQ otherwise; AXI valids assert the cycle after capture (registered outputs).
REQ-018 In WR_REQ, awvalid and wvalid SHALL assert together, each drops independently after its own handshake (aw_done/w_done flags), and WR_RESP is entered once both are done, including same-cycle completion.
REQ-019 In RD_REQ, arvalid SHALL hold until arready, then the FSM enters RD_RESP.
REQ-020 A valid SHALL never deassert before its ready, and address/data SHALL be stable while valid.
REQ-021 bready SHALL be 1 only in WR_RESP or during a B drain, and rready only in RD_RESP or during an R drain.
REQ-022 On B handshake, the initiator SHALL latch bresp, set rdata=0 and timeout=0, then go to RSP; on R handshake, it latches rdata/rresp, then goes to RSP.
REQ-023 A 16-bit timeout counter SHALL clear on entering WR_RESP/RD_RESP, increment each cycle there, and at TIMEOUT_CYCLES-1 without handshake force rsp_resp=2'b10, rsp_timeout=1, go to RSP, and set drain_b or drain_r.
REQ-024 A drain flag SHALL clear on the next bvalid (or rvalid) handshake, which is discarded, and req_ready stays 0 while any drain flag is set.
REQ-025 WR_REQ and RD_REQ SHALL have no timeout, per AXI rules.
REQ-026 In RSP, rsp_valid SHALL be 1 and outputs hold until rsp_ready, then the FSM returns to IDLE; minimum write latency is capture to rsp_valid = 3 cycles with ready slave.
REQ-027 awprot and arprot SHALL be constant 3'b000.
REQ-028 If a handshake and the timeout terminal count coincide, the handshake SHALL win and no drain is set.

Reset
REQ-029 On areset, the initiator SHALL enter IDLE, clear all valids, readies and rsp_* outputs, clear the counter, done flags and drain flags, and set busy=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no completion emitted, and outputs reach reset values asynchronously.

Structure
REQ-031 The state enum and the constants AXI_RESP_OKAY/AXI_RESP_SLVERR (2'b00/2'b10) SHALL live in lynxTypes.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Write 0x10 <- 0xDEADBEEF, wstrb 0xFF, slave with immediate ready -> one AW+W beat; rsp_resp=00, rsp_timeout=0, rsp_valid 3 cycles after capture.
REQ-034 Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles, exactly one completion.
REQ-035 Read 0x20 with slave rdata 0x1234 and rresp=00 after 2 cycles -> rsp_rdata=0x1234, rsp_resp=00.
REQ-036 TIMEOUT_CYCLES=8, slave never sends B -> rsp_resp=10 and rsp_timeout=1 at cycle 8 of WR_RESP; a late bvalid is sunk with req_ready=0 until it arrives.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready=0 throughout.
REQ-038 areset asserted during RD_RESP -> arvalid, rready and rsp_valid go to 0 immediately; the next read completes normally.

Source files
------------

// File: rtl/axil_ctrl_initiator_pkg.sv
// rtl/axil_ctrl_initiator_pkg.sv - shared widths, AXI response codes and FSM state encoding
package axil_ctrl_initiator_pkg;

    localparam int AXI_ADDR_BITS  = 64;
    localparam int AXIL_DATA_BITS = 64;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

endpackage

// File: rtl/axil_ctrl_initiator_if.sv
// rtl/axil_ctrl_initiator_if.sv - AXI4-Lite control bus with master/slave views
interface axil_ctrl_initiator_if;
    import axil_ctrl_initiator_pkg::*;

    logic [AXI_ADDR_BITS-1:0]    awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [AXIL_DATA_BITS-1:0]   wdata;
    logic [AXIL_DATA_BITS/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_BITS-1:0]    araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [AXIL_DATA_BITS-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axil_ctrl_initiator.sv
// rtl/axil_ctrl_initiator.sv - single-outstanding AXI4-Lite command initiator with B/R timeout and drain
module axil_ctrl_initiator
    import axil_ctrl_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [AXI_ADDR_BITS-1:0]    req_addr,
    input  logic [AXIL_DATA_BITS-1:0]   req_wdata,
    input  logic [AXIL_DATA_BITS/8-1:0] req_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXIL_DATA_BITS-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_timeout,
    output logic                        busy,
    axil_ctrl_initiator_if.master       m_axi_ctrl
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]                  state;
    logic                        aw_done;
    logic                        w_done;
    logic                        drain_b;
    logic                        drain_r;
    logic [15:0]                 tmo_cnt;
    logic [AXI_ADDR_BITS-1:0]    addr_q;
    logic [AXIL_DATA_BITS-1:0]   wdata_q;
    logic [AXIL_DATA_BITS/8-1:0] wstrb_q;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    // Bus outputs decode registered state only, so they change one cycle after capture.
    assign m_axi_ctrl.awaddr  = addr_q;
    assign m_axi_ctrl.awprot  = 3'b000;
    assign m_axi_ctrl.awvalid = (state == ST_WR_REQ) && !aw_done;
    assign m_axi_ctrl.wdata   = wdata_q;
    assign m_axi_ctrl.wstrb   = wstrb_q;
    assign m_axi_ctrl.wvalid  = (state == ST_WR_REQ) && !w_done;
    assign m_axi_ctrl.bready  = (state == ST_WR_RESP) || drain_b;
    assign m_axi_ctrl.araddr  = addr_q;
    assign m_axi_ctrl.arprot  = 3'b000;
    assign m_axi_ctrl.arvalid = (state == ST_RD_REQ);
    assign m_axi_ctrl.rready  = (state == ST_RD_RESP) || drain_r;

    assign aw_hs = m_axi_ctrl.awvalid && m_axi_ctrl.awready;
    assign w_hs  = m_axi_ctrl.wvalid  && m_axi_ctrl.wready;
    assign b_hs  = m_axi_ctrl.bvalid  && m_axi_ctrl.bready;
    assign ar_hs = m_axi_ctrl.arvalid && m_axi_ctrl.arready;
    assign r_hs  = m_axi_ctrl.rvalid  && m_axi_ctrl.rready;

    assign req_ready = (state == ST_IDLE) && !drain_b && !drain_r;
    assign rsp_valid = (state == ST_RSP);
    assign busy      = (state != ST_IDLE) || drain_b || drain_r;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= ST_IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            drain_b     <= 1'b0;
            drain_r     <= 1'b0;
            tmo_cnt     <= 16'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata   <= '0;
            rsp_resp    <= AXI_RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            // A response arriving after its timeout is accepted and thrown away.
            if (drain_b && b_hs) drain_b <= 1'b0;
            if (drain_r && r_hs) drain_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= req_wr ? ST_WR_REQ : ST_RD_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        tmo_cnt <= 16'd0;
                        state   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    // Handshake takes priority over the terminal count.
                    if (b_hs) begin
                        rsp_resp    <= m_axi_ctrl.bresp;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RSP;
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        rsp_resp    <= AXI_RESP_SLVERR;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        drain_b     <= 1'b1;
                        state       <= ST_RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RD_REQ: begin
                    if (ar_hs) begin
                        tmo_cnt <= 16'd0;
                        state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (r_hs) begin
                        rsp_resp    <= m_axi_ctrl.rresp;
                        rsp_rdata   <= m_axi_ctrl.rdata;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RSP;
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        rsp_resp    <= AXI_RESP_SLVERR;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        drain_r     <= 1'b1;
                        state       <= ST_RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_ctrl_initiator.sv
// tb/tb_axil_ctrl_initiator.sv - randomized self-checking bench with a delay-programmable AXI4-Lite slave
module tb_axil_ctrl_initiator;
    import axil_ctrl_initiator_pkg::*;

    localparam int T = 8;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        busy;

    axil_ctrl_initiator_if ax();

    axil_ctrl_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axi_ctrl(ax)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail = 0;

    // Slave knobs: h_* = cycles a valid is held until ready, d_* = cycles from request to response.
    int          h_aw = 1, h_w = 1, h_ar = 1, d_b = 0, d_r = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [63:0] s_rdata = '0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_timer = 0, r_timer = 0;
    bit          aw_seen = 0, w_seen = 0;
    int          b_hs_cnt = 0, r_hs_cnt = 0, rsp_count = 0;
    logic [63:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [7:0]  cap_wstrb;

    wire aw_hs = ax.awvalid && ax.awready;
    wire w_hs  = ax.wvalid && ax.wready;
    wire ar_hs = ax.arvalid && ax.arready;

    assign ax.awready = ax.awvalid && (aw_cnt >= h_aw - 1);
    assign ax.wready  = ax.wvalid && (w_cnt >= h_w - 1);
    assign ax.arready = ax.arvalid && (ar_cnt >= h_ar - 1);
    assign ax.bresp   = s_bresp;
    assign ax.rresp   = s_rresp;
    assign ax.rdata   = s_rdata;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_seen <= 0; w_seen <= 0;
            b_timer <= 0; r_timer <= 0; ax.bvalid <= 1'b0; ax.rvalid <= 1'b0;
        end else begin
            if (aw_hs) begin aw_cnt <= 0; cap_awaddr <= ax.awaddr; end
            else if (ax.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin w_cnt <= 0; cap_wdata <= ax.wdata; cap_wstrb <= ax.wstrb; end
            else if (ax.wvalid) w_cnt <= w_cnt + 1;
            if (ar_hs) begin ar_cnt <= 0; cap_araddr <= ax.araddr; end
            else if (ax.arvalid) ar_cnt <= ar_cnt + 1;

            if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
                aw_seen <= 0; w_seen <= 0;
                if (d_b == 0) ax.bvalid <= 1'b1; else b_timer <= d_b;
            end else begin
                if (aw_hs) aw_seen <= 1;
                if (w_hs) w_seen <= 1;
            end
            if (b_timer > 0) begin b_timer <= b_timer - 1; if (b_timer == 1) ax.bvalid <= 1'b1; end
            if (ax.bvalid && ax.bready) begin ax.bvalid <= 1'b0; b_hs_cnt <= b_hs_cnt + 1; end

            if (ar_hs) begin
                if (d_r == 0) ax.rvalid <= 1'b1; else r_timer <= d_r;
            end
            if (r_timer > 0) begin r_timer <= r_timer - 1; if (r_timer == 1) ax.rvalid <= 1'b1; end
            if (ax.rvalid && ax.rready) begin ax.rvalid <= 1'b0; r_hs_cnt <= r_hs_cnt + 1; end
        end
    end

    always @(posedge aclk) if (!areset && rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;

    // Valid/payload stability and prot observation, plus per-channel valid-high cycle counters.
    int   proto_err = 0, aw_hi = 0, w_hi = 0;
    logic p_aw = 0, p_w = 0, p_ar = 0;
    logic [63:0] p_awaddr, p_wdata, p_araddr;
    always @(negedge aclk) begin
        if (areset) begin
            p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            if (p_aw && !(ax.awvalid && ax.awaddr == p_awaddr)) proto_err++;
            if (p_w && !(ax.wvalid && ax.wdata == p_wdata)) proto_err++;
            if (p_ar && !(ax.arvalid && ax.araddr == p_araddr)) proto_err++;
            if ((ax.awvalid && ax.awprot != 3'b000) || (ax.arvalid && ax.arprot != 3'b000)) proto_err++;
            if (ax.awvalid) aw_hi++;
            if (ax.wvalid) w_hi++;
            p_aw = ax.awvalid && !ax.awready; p_awaddr = ax.awaddr;
            p_w  = ax.wvalid && !ax.wready;   p_wdata  = ax.wdata;
            p_ar = ax.arvalid && !ax.arready; p_araddr = ax.araddr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the first negedge with rsp_valid=1 (lat = cycles since capture).
    task automatic do_req(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [7:0] st, output int lat);
        int guard = 0;
        req_wr = wr; req_addr = addr; req_wdata = wd; req_wstrb = st; req_valid = 1'b1;
        while (!req_ready && guard < 2000) begin @(negedge aclk); guard++; end
        @(negedge aclk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge aclk); lat++; end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        n_checks++;
        if ({ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, rsp_valid, busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000000",
                {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, rsp_valid, busy});
        end
        n_checks++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== 67'b0) begin
            n_fail++; $display("FAIL reset_rsp: got %h/%b/%b required 0/00/0", rsp_rdata, rsp_resp, rsp_timeout);
        end
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_write_fast();
        int lat, c0;
        h_aw = 1; h_w = 1; d_b = 0; s_bresp = 2'b00;
        c0 = rsp_count;
        do_req(1'b1, 64'h10, 64'hDEADBEEF, 8'hFF, lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL wr_fast_latency: got %0d required 3", lat); end
        n_checks++;
        if ({rsp_resp, rsp_timeout, rsp_rdata} !== {2'b00, 1'b0, 64'h0}) begin
            n_fail++; $display("FAIL wr_fast_rsp: got %b/%b/%h required 00/0/0", rsp_resp, rsp_timeout, rsp_rdata);
        end
        n_checks++;
        if ({cap_awaddr, cap_wdata, cap_wstrb} !== {64'h10, 64'hDEADBEEF, 8'hFF}) begin
            n_fail++; $display("FAIL wr_fast_payload: got %h %h %h required 10 deadbeef ff", cap_awaddr, cap_wdata, cap_wstrb);
        end
        ack_rsp();
        n_checks++;
        if (rsp_count !== c0 + 1) begin n_fail++; $display("FAIL wr_fast_count: got %0d required %0d", rsp_count, c0 + 1); end
    endtask

    task automatic test_write_aw_delay();
        int lat, c0, aw0, w0;
        h_aw = 4; h_w = 1; d_b = 0; s_bresp = 2'b00;
        c0 = rsp_count; aw0 = aw_hi; w0 = w_hi;
        do_req(1'b1, 64'h48, 64'h0123456789ABCDEF, 8'h0F, lat);
        n_checks++;
        if ({aw_hi - aw0, w_hi - w0} !== {32'd4, 32'd1}) begin
            n_fail++; $display("FAIL aw_delay_valid_cycles: got aw=%0d w=%0d required aw=4 w=1", aw_hi - aw0, w_hi - w0);
        end
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL aw_delay_latency: got %0d required 6", lat); end
        ack_rsp();
        repeat (3) @(negedge aclk);
        n_checks++;
        if (rsp_count !== c0 + 1) begin n_fail++; $display("FAIL aw_delay_count: got %0d required %0d", rsp_count, c0 + 1); end
        h_aw = 1;
    endtask

    task automatic test_read();
        int lat;
        h_ar = 1; d_r = 2; s_rdata = 64'h1234; s_rresp = 2'b00;
        do_req(1'b0, 64'h20, 64'h0, 8'h0, lat);
        n_checks++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {64'h1234, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL read_rsp: got %h/%b/%b required 1234/00/0", rsp_rdata, rsp_resp, rsp_timeout);
        end
        n_checks++;
        if ({cap_araddr, 32'(lat)} !== {64'h20, 32'd5}) begin
            n_fail++; $display("FAIL read_addr_latency: got %h/%0d required 20/5", cap_araddr, lat);
        end
        ack_rsp();
    endtask

    task automatic test_timeout();
        int lat, b0, guard, bad;
        h_aw = 1; h_w = 1; d_b = 12; s_bresp = 2'b00;
        b0 = b_hs_cnt;
        do_req(1'b1, 64'h30, 64'h55, 8'h01, lat);
        n_checks++;
        if ({rsp_resp, rsp_timeout, 32'(lat)} !== {2'b10, 1'b1, 32'(T + 2)}) begin
            n_fail++; $display("FAIL timeout_rsp: got %b/%b lat=%0d required 10/1 lat=%0d", rsp_resp, rsp_timeout, lat, T + 2);
        end
        ack_rsp();
        guard = 0; bad = 0;
        while (b_hs_cnt == b0 && guard < 40) begin
            if (req_ready || !busy) bad++;
            @(negedge aclk); guard++;
        end
        n_checks++;
        if ({bad, b_hs_cnt - b0} !== {32'd0, 32'd1}) begin
            n_fail++; $display("FAIL timeout_drain: got early_ready=%0d drained=%0d required 0/1", bad, b_hs_cnt - b0);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ready_after_drain: got %b required 1", req_ready); end
        d_b = 0; s_bresp = 2'b01;
        do_req(1'b1, 64'h38, 64'h66, 8'h03, lat);
        n_checks++;
        if ({rsp_resp, rsp_timeout} !== {2'b01, 1'b0}) begin
            n_fail++; $display("FAIL after_drain_rsp: got %b/%b required 01/0", rsp_resp, rsp_timeout);
        end
        ack_rsp();
    endtask

    task automatic test_timeout_boundary();
        int lat;
        d_b = T - 1; s_bresp = 2'b11;
        do_req(1'b1, 64'h40, 64'h77, 8'hF0, lat);
        n_checks++;
        if ({rsp_resp, rsp_timeout, 32'(lat)} !== {2'b11, 1'b0, 32'(T + 2)}) begin
            n_fail++; $display("FAIL boundary_rsp: got %b/%b lat=%0d required 11/0 lat=%0d", rsp_resp, rsp_timeout, lat, T + 2);
        end
        ack_rsp();
        n_checks++;
        if ({busy, req_ready} !== 2'b01) begin n_fail++; $display("FAIL boundary_no_drain: got busy/ready %b required 01", {busy, req_ready}); end
        d_b = 0;
    endtask

    task automatic test_rsp_hold();
        int lat;
        logic [63:0] exp_d;
        exp_d = {$urandom, $urandom};
        d_r = 0; s_rdata = exp_d; s_rresp = 2'b01;
        do_req(1'b0, 64'h50, 64'h0, 8'h0, lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, req_ready, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, 1'b0, exp_d, 2'b01, 1'b0}) begin
                n_fail++; $display("FAIL rsp_hold_cycle%0d: got v=%b rdy=%b %h/%b/%b required 1/0 %h/01/0",
                    i, rsp_valid, req_ready, rsp_rdata, rsp_resp, rsp_timeout, exp_d);
            end
            s_rdata = ~s_rdata;
            @(negedge aclk);
        end
        ack_rsp();
    endtask

    task automatic test_reset_mid();
        int guard, c0, lat;
        h_ar = 1; d_r = 20;
        c0 = rsp_count;
        req_wr = 1'b0; req_addr = 64'h60; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge aclk); guard++; end
        @(negedge aclk);
        req_valid = 1'b0;
        guard = 0;
        while (!ax.rready && guard < 20) begin @(negedge aclk); guard++; end
        @(negedge aclk);
        areset = 1'b1;
        #1;
        n_checks++;
        if ({ax.arvalid, ax.rready, rsp_valid, busy} !== 4'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %b required 0000", {ax.arvalid, ax.rready, rsp_valid, busy});
        end
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (rsp_count !== c0) begin n_fail++; $display("FAIL reset_mid_no_completion: got %0d required %0d", rsp_count, c0); end
        d_r = 1; s_rdata = 64'hCAFE_F00D; s_rresp = 2'b00;
        do_req(1'b0, 64'h68, 64'h0, 8'h0, lat);
        n_checks++;
        if ({rsp_rdata, rsp_resp, rsp_timeout, 32'(lat)} !== {64'hCAFE_F00D, 2'b00, 1'b0, 32'd4}) begin
            n_fail++; $display("FAIL reset_mid_next_read: got %h/%b/%b lat=%0d required cafef00d/00/0 lat=4", rsp_rdata, rsp_resp, rsp_timeout, lat);
        end
        ack_rsp();
    endtask

    task automatic test_random();
        int lat, exp_lat, dly;
        bit wr, to;
        logic [63:0] a, wd, rd;
        logic [7:0]  st;
        logic [1:0]  rs;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); a = {$urandom, $urandom}; wd = {$urandom, $urandom}; st = 8'($urandom);
            rd = {$urandom, $urandom}; rs = 2'($urandom);
            h_aw = $urandom_range(1, 3); h_w = $urandom_range(1, 3); h_ar = $urandom_range(1, 3);
            dly = $urandom_range(0, 11);
            d_b = dly; d_r = dly; s_bresp = rs; s_rresp = rs; s_rdata = rd;
            // The response lands in cycle dly+1 of the wait; anything later than T cycles is a timeout.
            to = (dly >= T);
            exp_lat = (wr ? ((h_aw > h_w) ? h_aw : h_w) : h_ar) + (to ? T : dly + 1) + 1;
            do_req(wr, a, wd, st, lat);
            n_checks++;
            if (lat !== exp_lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d required %0d", i, lat, exp_lat); end
            n_checks++;
            if ({rsp_resp, rsp_timeout} !== (to ? 3'b101 : {rs, 1'b0})) begin
                n_fail++; $display("FAIL rand%0d_resp: got %b/%b required %b/%b", i, rsp_resp, rsp_timeout, to ? 2'b10 : rs, to);
            end
            n_checks++;
            if (rsp_rdata !== ((wr || to) ? 64'h0 : rd)) begin
                n_fail++; $display("FAIL rand%0d_rdata: got %h required %h", i, rsp_rdata, (wr || to) ? 64'h0 : rd);
            end
            n_checks++;
            if (wr ? ({cap_awaddr, cap_wdata, cap_wstrb} !== {a, wd, st}) : (cap_araddr !== a)) begin
                n_fail++; $display("FAIL rand%0d_payload: got aw=%h w=%h s=%h ar=%h required addr=%h data=%h strb=%h",
                    i, cap_awaddr, cap_wdata, cap_wstrb, cap_araddr, a, wd, st);
            end
            repeat ($urandom_range(0, 2)) @(negedge aclk);
            ack_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_write_aw_delay();
        test_read();
        test_timeout();
        test_timeout_boundary();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        repeat (20) @(negedge aclk);
        n_checks++;
        if (proto_err !== 0) begin n_fail++; $display("FAIL protocol_stability: got %0d violations required 0", proto_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
